stream_demux_1_4: RTL and testbench

//   Registered 1-to-4 stream demultiplexer: the inverse of the 4:1 data mux.
//   A single valid/ready input stream carries a W-bit payload plus a channel

---
 rtl/stream_demux_1_4_pkg.sv | 18 +
 rtl/stream_demux_1_4_if.sv | 32 +++
 rtl/stream_demux_1_4_slot.sv | 46 ++++
 rtl/stream_demux_1_4.sv | 60 ++++++
 tb/tb_stream_demux_1_4.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/stream_demux_1_4_pkg.sv
// Shared constants, types and the channel-select decode for the 1:4 stream demux.
package stream_demux_pkg;

    localparam int PKG_W     = 4;
    localparam int PKG_SEL_W = 2;
    localparam int PKG_CNT_W = 8;
    localparam int N_CH      = 2 ** PKG_SEL_W;

    typedef logic [PKG_SEL_W-1:0] ch_sel_t;

    function automatic logic [N_CH-1:0] sel_onehot(input ch_sel_t s);
        logic [N_CH-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/stream_demux_1_4_if.sv
// Bundle of the input stream and the four per-channel output streams.
interface stream_demux_1_4_if
    import stream_demux_pkg::*;
#(
    parameter int W     = PKG_W,
    parameter int SEL_W = PKG_SEL_W,
    parameter int CNT_W = PKG_CNT_W
);
    localparam int N = 2 ** SEL_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [SEL_W-1:0] in_sel;
    logic [N-1:0]     out_valid;
    logic [N-1:0]     out_ready;
    logic [N*W-1:0]   out_data;
    logic [N*CNT_W-1:0] out_cnt;

    // Source of the input stream and consumer of the output streams.
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_cnt
    );

    // The demultiplexer itself.
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_cnt
    );

endinterface

// File: rtl/stream_demux_1_4_slot.sv
// One-entry output register slice with a wrapping delivered-word counter.
module demux_out_slot #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [W-1:0]     data,
    output logic [CNT_W-1:0] cnt
);

    logic             valid_q, valid_d;
    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop_fire;

    // push is only raised when the slot is empty or popping on this edge,
    // so a refill and a pop on the same edge keep the slot full.
    always_comb begin
        pop_fire = valid_q & pop_ready;
        valid_d  = push | (valid_q & ~pop_ready);
        data_d   = push ? push_data : data_q;
        cnt_d    = pop_fire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/stream_demux_1_4.sv
// Registered 1:4 stream demultiplexer: select decode, in_ready mux and four slots.
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int W     = PKG_W,
    parameter int SEL_W = PKG_SEL_W,
    parameter int CNT_W = PKG_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    stream_demux_1_4_if.slave        bus
);

    localparam int N = 2 ** SEL_W;

    // Handshake: a word moves on any edge where its valid and ready are both
    // high; valid never waits on ready, and in_ready looks only at the slot
    // selected by in_sel, so one stalled channel cannot block the others.
    ch_sel_t          sel;
    logic             in_ready;
    logic [N-1:0]     push;
    logic [N-1:0]     slot_valid;
    logic [W-1:0]     slot_data [N];
    logic [CNT_W-1:0] slot_cnt  [N];

    assign sel      = bus.in_sel;
    assign in_ready = ~slot_valid[sel] | bus.out_ready[sel];

    always_comb begin
        push = '0;
        if (bus.in_valid && in_ready) begin
            push = sel_onehot(sel);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_slot
        demux_out_slot #(
            .W     (W),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_data (bus.in_data),
            .pop_ready (bus.out_ready[i]),
            .valid     (slot_valid[i]),
            .data      (slot_data[i]),
            .cnt       (slot_cnt[i])
        );

        assign bus.out_data[i*W +: W]         = slot_data[i];
        assign bus.out_cnt[i*CNT_W +: CNT_W]  = slot_cnt[i];
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = slot_valid;

    a_push_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(push));

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Randomized and directed bench for stream_demux_1_4 with a per-channel scoreboard.
module tb_stream_demux_1_4;

    localparam int W     = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;
    localparam int N     = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    stream_demux_1_4_if #(.W(W), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    stream_demux_1_4 #(.W(W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: each channel is a FIFO of words accepted but not yet
    // delivered; a channel can take a word when, after this edge's delivery,
    // its FIFO is empty.
    logic [W-1:0] exp_q [N][$];
    int           cnt_model [N];
    int           deliv [N];
    bit           acc_flag;
    event         mon_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge rst) begin
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            cnt_model[i] = 0;
        end
    end

    // Monitor: compare every channel each cycle, then retire delivered words.
    always @(negedge clk) begin
        acc_flag = 1'b0;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("out_valid[%0d]", i), 32'(bus.out_valid[i]), 32'(exp_q[i].size() != 0));
                if (exp_q[i].size() != 0 && bus.out_valid[i])
                    check($sformatf("out_data[%0d]", i), 32'(bus.out_data[i*W +: W]), 32'(exp_q[i][0]));
                check($sformatf("out_cnt[%0d]", i), 32'(bus.out_cnt[i*CNT_W +: CNT_W]), 32'(cnt_model[i] % 256));
                if (exp_q[i].size() != 0 && bus.out_ready[i]) begin
                    void'(exp_q[i].pop_front());
                    cnt_model[i]++;
                    deliv[i]++;
                end
            end
            ->mon_done;
        end
    end

    // Acceptance recorder: the expected word enters the scoreboard when issued.
    always @(mon_done) begin
        bit rdy;
        rdy = (exp_q[bus.in_sel].size() == 0);
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        if (bus.in_valid && rdy) begin
            exp_q[bus.in_sel].push_back(bus.in_data);
            acc_flag = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until accepted; returns the edges it took.
    task automatic send(input int sel, input logic [W-1:0] d, output int cyc);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_sel   = SEL_W'(sel);
        bus.in_data  = d;
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 64) begin
            @(posedge clk);
            acc = acc_flag;
            cyc++;
        end
        if (!acc) check("send_timeout", 32'(cyc), 32'(0));
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = '0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int total;
        bit acc;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.out_ready = '0;
        for (int i = 0; i < N; i++) deliv[i] = 0;

        // 1. reset, then idle
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_out_cnt", 32'(bus.out_cnt), 32'h0);
        check("reset_in_ready", 32'(bus.in_ready), 32'h1);
        tick();

        // 2. fill every channel, nothing consumed
        send(0, 4'ha, cyc);
        send(1, 4'hb, cyc);
        send(2, 4'hc, cyc);
        send(3, 4'hd, cyc);
        #1;
        check("fill_out_valid", 32'(bus.out_valid), 32'hf);
        check("fill_out_data", 32'(bus.out_data), 32'hdcba);
        tick();

        // 3. stalled channel 1 refuses, channel 2 proceeds
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd1;
        bus.in_data  = 4'h5;
        #2;
        check("stall_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        tick();
        check("stall_hold_data", 32'(bus.out_data[1*W +: W]), 32'hb);
        bus.out_ready[2] = 1'b1;
        send(2, 4'h6, cyc);
        check("other_ch_accept_cycles", 32'(cyc), 32'd1);
        bus.out_ready[2] = 1'b0;
        tick();

        // 4. full-throughput stream on channel 3
        do_reset();
        bus.out_ready[3] = 1'b1;
        deliv[3] = 0;
        total = 0;
        for (int k = 1; k <= 8; k++) begin
            send(3, 4'(k), cyc);
            total += cyc;
        end
        check("stream_cycles", 32'(total), 32'd8);
        repeat (3) tick();
        check("stream_delivered", 32'(deliv[3]), 32'd8);
        check("stream_cnt3", 32'(bus.out_cnt[3*CNT_W +: CNT_W]), 32'd8);

        // 5. counter wrap on channel 0
        do_reset();
        bus.out_ready = 4'b0001;
        total = 0;
        for (int k = 0; k < 257; k++) begin
            send(0, 4'($urandom_range(0, 15)), cyc);
            total += cyc;
        end
        check("wrap_cycles", 32'(total), 32'd257);
        repeat (3) tick();
        check("wrap_cnt0", 32'(bus.out_cnt[0 +: CNT_W]), 32'd1);
        check("wrap_cnt_others", 32'(bus.out_cnt[N*CNT_W-1:CNT_W]), 32'd0);

        // random traffic with random back-pressure
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            acc = acc_flag;
            #1;
            bus.out_ready = 4'($urandom_range(0, 15));
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sel   = 2'($urandom_range(0, 3));
                bus.in_data  = 4'($urandom_range(0, 15));
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'hf;
        repeat (4) tick();
        for (int i = 0; i < N; i++)
            check($sformatf("drain_empty[%0d]", i), 32'(exp_q[i].size()), 32'd0);

        // 6. asynchronous reset between edges
        bus.out_ready = 4'b0000;
        send(2, 4'h7, cyc);
        send(0, 4'h3, cyc);
        #1;
        rst = 1'b1;
        #1;
        check("async_out_valid", 32'(bus.out_valid), 32'h0);
        check("async_out_cnt", 32'(bus.out_cnt), 32'h0);
        check("async_in_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        send(1, 4'h9, cyc);
        check("post_reset_accept", 32'(cyc), 32'd1);
        #1;
        check("post_reset_valid", 32'(bus.out_valid), 32'b0010);
        check("post_reset_data", 32'(bus.out_data[1*W +: W]), 32'h9);
        bus.out_ready = 4'hf;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
